cookie_array: RTL and testbench

//  Parametrised WIDTH x HEIGHT cellular-automaton engine with an on-board sequencer.

---
 rtl/cookie_array.sv | 206 ++++++++++++++++++++
 tb/tb_cookie_array.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cookie_array.sv
// cookie_array: WIDTH x HEIGHT cellular-automaton engine with a command sequencer.
// The host serially loads a pattern, runs G generations under a programmable
// birth/survive rule, then reads the grid back serially.
// Optional macro TORUS_EN: neighbour coordinates wrap around the grid edges;
// when undefined, cells outside the grid read as dead.
module cookie_array #(
  parameter int         WIDTH        = 16,
  parameter int         HEIGHT       = 16,
  parameter int         GEN_W        = 8,
  parameter logic [8:0] BIRTH_MASK   = 9'h008,
  parameter logic [8:0] SURVIVE_MASK = 9'h00C
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic                                 load_start,
  input  logic                                 load_valid,
  input  logic                                 load_bit,
  input  logic                                 run_start,
  input  logic [GEN_W-1:0]                     gen_count,
  input  logic                                 dump_start,
  output logic                                 dump_valid,
  output logic                                 dump_bit,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]    pop_count
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DUMP = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [N-1:0]     cells, cells_next, gen_cells;
  logic [IW-1:0]    idx, idx_next;
  logic [GEN_W-1:0] gen_left, gen_left_next;
  logic             busy_next, done_next, dv_next, db_next;
  logic [PW-1:0]    pop_next;

  // Count live 8-neighbours of cell (x,y); edge handling depends on TORUS_EN.
  function automatic logic [3:0] nb_count(input logic [N-1:0] c, input int x, input int y);
    logic [3:0] n;
    int         nx, ny;
    n = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0) begin
`ifdef TORUS_EN
          nx = (x + dx + WIDTH) % WIDTH;
          ny = (y + dy + HEIGHT) % HEIGHT;
          n  = n + {3'd0, c[ny*WIDTH+nx]};
`else
          nx = x + dx;
          ny = y + dy;
          if (nx >= 0 && nx < WIDTH && ny >= 0 && ny < HEIGHT) begin
            n = n + {3'd0, c[ny*WIDTH+nx]};
          end else begin
            n = n;
          end
`endif
        end else begin
          n = n;
        end
      end
    end
    return n;
  endfunction

  // Number of live cells in a grid image.
  function automatic logic [PW-1:0] popcount(input logic [N-1:0] c);
    logic [PW-1:0] cnt;
    cnt = {PW{1'b0}};
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{(PW-1){1'b0}}, c[i]};
    end
    return cnt;
  endfunction

  // One full generation of every cell, evaluated in parallel from the current grid.
  always_comb begin
    gen_cells = cells;
    for (int y = 0; y < HEIGHT; y++) begin
      for (int x = 0; x < WIDTH; x++) begin
        if (cells[y*WIDTH+x]) begin
          gen_cells[y*WIDTH+x] = SURVIVE_MASK[nb_count(cells, x, y)];
        end else begin
          gen_cells[y*WIDTH+x] = BIRTH_MASK[nb_count(cells, x, y)];
        end
      end
    end
  end

  // Sequencer next-state, grid update and output decode; en=0 holds everything.
  always_comb begin
    state_next    = state;
    cells_next    = cells;
    idx_next      = idx;
    gen_left_next = gen_left;
    done_next     = 1'b0;
    dv_next       = 1'b0;
    db_next       = dump_bit;
    if (en) begin
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state_next = S_LOAD;
            idx_next   = {IW{1'b0}};
          end else if (run_start) begin
            state_next    = S_RUN;
            gen_left_next = gen_count;
          end else if (dump_start) begin
            state_next = S_DUMP;
            idx_next   = {IW{1'b0}};
          end else begin
            state_next = S_IDLE;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            cells_next[idx] = load_bit;
            if (idx == IW'(N - 1)) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
              idx_next   = {IW{1'b0}};
            end else begin
              idx_next = idx + {{(IW-1){1'b0}}, 1'b1};
            end
          end else begin
            idx_next = idx;
          end
        end
        S_RUN: begin
          // A zero generation count completes without touching the grid.
          if (gen_left == {GEN_W{1'b0}}) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            cells_next    = gen_cells;
            gen_left_next = gen_left - {{(GEN_W-1){1'b0}}, 1'b1};
            if (gen_left == {{(GEN_W-1){1'b0}}, 1'b1}) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = S_RUN;
            end
          end
        end
        S_DUMP: begin
          dv_next = 1'b1;
          db_next = cells[idx];
          if (idx == IW'(N - 1)) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
            idx_next   = {IW{1'b0}};
          end else begin
            idx_next = idx + {{(IW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end else begin
      state_next = state;
    end
    busy_next = (state_next != S_IDLE);
    pop_next  = popcount(cells_next);
  end

  // State, grid and registered outputs; synchronous active-low reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cells      <= {N{1'b0}};
      idx        <= {IW{1'b0}};
      gen_left   <= {GEN_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      dump_valid <= 1'b0;
      dump_bit   <= 1'b0;
      pop_count  <= {PW{1'b0}};
    end else begin
      state      <= state_next;
      cells      <= cells_next;
      idx        <= idx_next;
      gen_left   <= gen_left_next;
      busy       <= busy_next;
      done       <= done_next;
      dump_valid <= dv_next;
      dump_bit   <= db_next;
      if (done_next) begin
        pop_count <= pop_next;
      end else begin
        pop_count <= pop_count;
      end
    end
  end

endmodule

// File: tb/tb_cookie_array.sv
// Directed self-checking bench for cookie_array on a 5x5 grid with the B3/S23 rule.
module tb_cookie_array;

  localparam logic [24:0] HORIZ   = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
  localparam logic [24:0] VERT    = (25'd1 << 7)  | (25'd1 << 12) | (25'd1 << 17);
  localparam logic [24:0] CORNERS = (25'd1 << 0)  | (25'd1 << 4)  | (25'd1 << 20) | (25'd1 << 24);
  localparam logic [24:0] MIXED   = (25'd1 << 0)  | (25'd1 << 3)  | (25'd1 << 6)  | (25'd1 << 9) | (25'd1 << 24);

  logic       clk = 1'b0;
  logic       rst_n, en, load_start, load_valid, load_bit, run_start, dump_start;
  logic [7:0] gen_count;
  logic       dump_valid, dump_bit, busy, done;
  logic [4:0] pop_count;

  int checks = 0;
  int errors = 0;

  cookie_array #(.WIDTH(5), .HEIGHT(5), .GEN_W(8),
                 .BIRTH_MASK(9'h008), .SURVIVE_MASK(9'h00C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
    .run_start(run_start), .gen_count(gen_count), .dump_start(dump_start),
    .dump_valid(dump_valid), .dump_bit(dump_bit),
    .busy(busy), .done(done), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial load of a 25-bit pattern with one idle gap in the stream.
  task automatic do_load(input logic [24:0] pat);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b exp 1", busy); end
    for (int k = 0; k < 25; k++) begin
      if (k == 5) begin
        load_valid = 1'b0; load_bit = ~pat[k];
        tick();
      end
      load_valid = 1'b1; load_bit = pat[k];
      tick();
    end
    load_valid = 1'b0; load_bit = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL load_done got done=%b busy=%b exp done=1 busy=0", done, busy);
    end
    checks++;
    if (pop_count !== 5'($countones(pat))) begin
      errors++; $display("FAIL load_pop got %0d exp %0d", pop_count, $countones(pat));
    end
  endtask

  // Start a run and count cycles from acceptance to done (bounded).
  task automatic do_run(input logic [7:0] g, output int lat);
    run_start = 1'b1; gen_count = g;
    tick();
    run_start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  // Serial readout; collects every qualified bit until done (bounded).
  task automatic do_dump(output logic [24:0] got, output int nbits);
    got = 25'd0; nbits = 0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (dump_valid === 1'b1) begin
        if (nbits < 25) got[nbits] = dump_bit;
        nbits++;
      end
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    logic [24:0] got; int nb;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0 || dump_bit !== 1'b0 || pop_count !== 5'd0) begin
      errors++; $display("FAIL reset_outputs got busy=%b done=%b dv=%b db=%b pop=%0d exp all 0",
                         busy, done, dump_valid, dump_bit, pop_count);
    end
    do_dump(got, nb);
    checks++;
    if (got !== 25'd0 || nb != 25) begin
      errors++; $display("FAIL reset_cells got %h (%0d bits) exp 0 (25 bits)", got, nb);
    end
  endtask

  task automatic test_blinker();
    logic [24:0] got; int nb, lat;
    do_load(HORIZ);
    do_run(8'd1, lat);
    checks++;
    if (lat != 1 || busy !== 1'b0) begin errors++; $display("FAIL blink1_latency got %0d exp 1", lat); end
    checks++;
    if (pop_count !== 5'd3) begin errors++; $display("FAIL blink1_pop got %0d exp 3", pop_count); end
    do_dump(got, nb);
    checks++;
    if (got !== VERT || nb != 25) begin errors++; $display("FAIL blink1_grid got %h exp %h", got, VERT); end
    checks++;
    if (pop_count !== 5'd3) begin errors++; $display("FAIL blink1_pop_after_dump got %0d exp 3", pop_count); end
    do_load(HORIZ);
    do_run(8'd2, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL blink2_latency got %0d exp 2", lat); end
    do_dump(got, nb);
    checks++;
    if (got !== HORIZ) begin errors++; $display("FAIL blink2_grid got %h exp %h", got, HORIZ); end
  endtask

  task automatic test_corners();
    logic [24:0] got; int nb, lat;
    logic [24:0] exp_grid;
    logic [4:0]  exp_pop;
`ifdef TORUS_EN
    exp_grid = CORNERS; exp_pop = 5'd4;
`else
    exp_grid = 25'd0;   exp_pop = 5'd0;
`endif
    do_load(CORNERS);
    do_run(8'd1, lat);
    checks++;
    if (pop_count !== exp_pop) begin errors++; $display("FAIL corners_pop got %0d exp %0d", pop_count, exp_pop); end
    do_dump(got, nb);
    checks++;
    if (got !== exp_grid) begin errors++; $display("FAIL corners_grid got %h exp %h", got, exp_grid); end
  endtask

  task automatic test_gen0();
    logic [24:0] got; int nb, lat;
    do_load(MIXED);
    run_start = 1'b1; gen_count = 8'd0;
    tick();
    run_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL gen0_accept got busy=%b done=%b exp 1/0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL gen0_done got done=%b busy=%b exp 1/0", done, busy);
    end
    checks++;
    if (pop_count !== 5'd5) begin errors++; $display("FAIL gen0_pop got %0d exp 5", pop_count); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL gen0_pulse got done=%b exp 0", done); end
    do_dump(got, nb);
    checks++;
    if (got !== MIXED) begin errors++; $display("FAIL gen0_grid got %h exp %h", got, MIXED); end
  endtask

  task automatic test_stall();
    logic [24:0] got; int nb, lat;
    do_load(HORIZ);
    // starts while en=0 must be ignored
    en = 1'b0; run_start = 1'b1; gen_count = 8'd3;
    tick();
    run_start = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_start_ignored got busy=%b exp 0", busy); end
    run_start = 1'b1; gen_count = 8'd3;
    tick();
    run_start = 1'b0;
    tick();
    lat = 1;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      lat++;
      if (done === 1'b1) break;
    end
    en = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 7) begin errors++; $display("FAIL stall_latency got %0d exp 7", lat); end
    do_dump(got, nb);
    checks++;
    if (got !== VERT) begin errors++; $display("FAIL stall_grid got %h exp %h", got, VERT); end
  endtask

  task automatic test_priority();
    logic [24:0] got; int nb, dv_seen, lat;
    // cells currently vertical; load horizontal with a competing run_start
    load_start = 1'b1; run_start = 1'b1; gen_count = 8'd2;
    tick();
    load_start = 1'b0; run_start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL prio_busy got %b exp 1", busy); end
    for (int k = 0; k < 25; k++) begin
      load_valid = 1'b1; load_bit = HORIZ[k];
      tick();
      if (k < 24 && done === 1'b1) begin
        checks++; errors++; $display("FAIL prio_early_done got done=1 at bit %0d exp 0", k);
      end
    end
    load_valid = 1'b0; load_bit = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL prio_load_done got %b exp 1", done); end
    do_dump(got, nb);
    checks++;
    if (got !== HORIZ) begin errors++; $display("FAIL prio_grid got %h exp %h", got, HORIZ); end
    // dump_start during RUN must be ignored
    run_start = 1'b1; gen_count = 8'd3;
    tick();
    run_start = 1'b0;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dv_seen = (dump_valid === 1'b1) ? 1 : 0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (dump_valid === 1'b1) dv_seen++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dump_valid === 1'b1) dv_seen++;
    end
    checks++;
    if (dv_seen != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL prio_dump_ignored got %0d dump_valid cycles busy=%b exp 0/0", dv_seen, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [24:0] got; int nb;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load_valid = 1'b1; load_bit = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pop_count !== 5'd0) begin
      errors++; $display("FAIL rst_mid_outputs got busy=%b done=%b pop=%0d exp 0/0/0", busy, done, pop_count);
    end
    do_dump(got, nb);
    checks++;
    if (got !== 25'd0 || nb != 25) begin errors++; $display("FAIL rst_mid_cells got %h exp 0", got); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
    run_start = 1'b0; gen_count = 8'd0; dump_start = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_blinker();
    test_corners();
    test_gen0();
    test_stall();
    test_priority();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
